// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one step per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish right after accept.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] One = WIDTH'(1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state;
  logic [2:0]       fn;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             res_neg;
  logic [CntW-1:0]  cnt;

  logic             a_signed, b_signed, a_neg, b_neg, is_div, neg_d;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             early;
  logic [WIDTH-1:0] early_res;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0] div_val, fix_res;

  // Operand decode at issue: magnitudes plus the sign the final result must carry.
  always_comb begin
    a_signed = !((funct3 == 3'd3) || (funct3 == 3'd5) || (funct3 == 3'd7));
    b_signed = a_signed && (funct3 != 3'd2);
    a_neg    = a_signed && op_a[WIDTH-1];
    b_neg    = b_signed && op_b[WIDTH-1];
    mag_a    = a_neg ? (~op_a + One) : op_a;
    mag_b    = b_neg ? (~op_b + One) : op_b;
    is_div   = funct3[2];
    if (!is_div) begin
      neg_d = a_neg ^ b_neg;
    end else if (funct3[1]) begin
      neg_d = a_neg;
    end else begin
      // Divide-by-zero quotient stays all-ones regardless of operand signs.
      neg_d = (a_neg ^ b_neg) && (op_b != '0);
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic div0, ovf;
  always_comb begin
    div0      = is_div && (op_b == '0);
    ovf       = is_div && !funct3[0] && (op_a == MinVal) && (op_b == '1);
    early     = div0 || ovf;
    early_res = '0;
    if (div0) begin
      early_res = funct3[1] ? op_a : '1;
    end else if (ovf) begin
      early_res = funct3[1] ? '0 : MinVal;
    end
  end
`else
  always_comb begin
    early     = 1'b0;
    early_res = '0;
  end
`endif

  // One iteration step; acc_lo holds the multiplier (mul) or the dividend/quotient (div).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (fn[2]) begin
      hi_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_step = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod    = {acc_hi, acc_lo};
    prod_c  = res_neg ? (~prod + (2 * WIDTH)'(1)) : prod;
    div_val = fn[1] ? acc_hi : acc_lo;
    if (fn[2]) begin
      fix_res = res_neg ? (~div_val + One) : div_val;
    end else if (fn == 3'd0) begin
      fix_res = prod_c[WIDTH-1:0];
    end else begin
      fix_res = prod_c[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      fn      <= '0;
      rd_q    <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      res_neg <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (flush) begin
      state <= StIdle;
      busy  <= 1'b0;
      wb_en <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
          wb_en <= 1'b0;
          if (start) begin
            fn      <= funct3;
            rd_q    <= rd_in;
            res_neg <= neg_d;
            opnd    <= is_div ? mag_b : mag_a;
            acc_hi  <= '0;
            acc_lo  <= is_div ? mag_a : mag_b;
            cnt     <= CntW'(WIDTH);
            busy    <= 1'b1;
            if (early) begin
              state   <= StDone;
              wb_en   <= (rd_in != 5'd0);
              wb_addr <= rd_in;
              wb_data <= early_res;
            end else begin
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_hi <= hi_step;
          acc_lo <= lo_step;
          cnt    <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            state <= StFix;
          end
        end
        StFix: begin
          state   <= StDone;
          busy    <= 1'b0;
          wb_en   <= (rd_q != 5'd0);
          wb_addr <= rd_q;
          wb_data <= fix_res;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, corner cases, latency, flush, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, pulses, busy_last;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_in   (rd_in),
    .flush   (flush),
    .busy    (busy),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op before edge 0 and watch 40 edges; edge k is sampled #1 after it.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    lat = -1;
    pulses = 0;
    busy_last = -1;
    @(negedge clk);
    start = 1'b1;
    funct3 = f3;
    op_a = a;
    op_b = b;
    rd_in = rd;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) start = 1'b0;
      if (busy) busy_last = k;
      if (wb_en) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_data, input logic [4:0] rd,
                              input int exp_lat, input int exp_busy);
    check_eq({tag, "_data"}, wb_data, exp_data);
    check_eq({tag, "_addr"}, 32'(wb_addr), 32'(rd));
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
    check_eq({tag, "_busy_last"}, 32'(busy_last), 32'(exp_busy));
  endtask

  int eo_lat, eo_busy;

  initial begin
`ifdef MULDIV_EARLY_OUT_EN
    eo_lat  = 0;
    eo_busy = 0;
`else
    eo_lat  = 33;
    eo_busy = 32;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    funct3 = 3'd0;
    op_a = '0;
    op_b = '0;
    rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wb_en", 32'(wb_en), 32'd0);
    check_eq("rst_wb_addr", 32'(wb_addr), 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    check_result("mul", 32'hFFFF_FFEB, 5'd5, 33, 32);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    check_result("mulh", 32'h4000_0000, 5'd1, 33, 32);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    check_result("mulhu", 32'hFFFF_FFFE, 5'd2, 33, 32);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
    check_result("mulhsu", 32'hFFFF_FFFF, 5'd3, 33, 32);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    check_result("div_neg", 32'hFFFF_FFFD, 5'd4, 33, 32);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check_result("rem_neg", 32'hFFFF_FFFF, 5'd6, 33, 32);
    run_op(3'd5, 32'd100, 32'd7, 5'd8);
    check_result("divu", 32'd14, 5'd8, 33, 32);
    run_op(3'd7, 32'd100, 32'd7, 5'd9);
    check_result("remu", 32'd2, 5'd9, 33, 32);
    run_op(3'd4, 32'd20, 32'hFFFF_FFFD, 5'd10);
    check_result("div_negb", 32'hFFFF_FFFA, 5'd10, 33, 32);
    run_op(3'd6, 32'd20, 32'hFFFF_FFFD, 5'd11);
    check_result("rem_negb", 32'd2, 5'd11, 33, 32);

    run_op(3'd5, 32'd100, 32'd0, 5'd12);
    check_result("divu_z", 32'hFFFF_FFFF, 5'd12, eo_lat, eo_busy);
    run_op(3'd7, 32'd100, 32'd0, 5'd13);
    check_result("remu_z", 32'd100, 5'd13, eo_lat, eo_busy);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd0, 5'd14);
    check_result("div_z", 32'hFFFF_FFFF, 5'd14, eo_lat, eo_busy);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    check_result("div_ovf", 32'h8000_0000, 5'd15, eo_lat, eo_busy);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    check_result("rem_ovf", 32'd0, 5'd16, eo_lat, eo_busy);

    // Flush mid-op, a start ignored while busy, then a fresh op right after the flush.
    lat = -1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (k == 0) begin
        start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5;
      end else if (k == 5) begin
        start = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd20;
      end else if (k == 10) begin
        flush = 1'b1;
      end else if (k == 11) begin
        start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd7;
      end
      @(posedge clk);
      #1;
      if (k == 10) check_eq("flush_busy", 32'(busy), 32'd0);
      if (k == 11) check_eq("restart_busy", 32'(busy), 32'd1);
      if (wb_en) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    start = 1'b0;
    check_eq("flush_pulses", 32'(pulses), 32'd1);
    check_eq("flush_wb_edge", 32'(lat), 32'd44);
    check_eq("flush_data", wb_data, 32'd12);
    check_eq("flush_addr", 32'(wb_addr), 32'd7);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd0);
    check_eq("rd0_pulses", 32'(pulses), 32'd0);
    check_eq("rd0_busy_last", 32'(busy_last), 32'd32);
    check_eq("rd0_data", wb_data, 32'hFFFF_FFEB);

    // Synchronous reset in the middle of a divide.
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = (k == 0);
      if (k == 0) begin
        funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
      end
      rst_n = (k != 20);
      @(posedge clk);
      #1;
      if (k == 19) check_eq("prerst_busy", 32'(busy), 32'd1);
      if (k == 20) begin
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_wb_en", 32'(wb_en), 32'd0);
        check_eq("midrst_addr", 32'(wb_addr), 32'd0);
        check_eq("midrst_data", wb_data, 32'd0);
      end
      if (wb_en) pulses++;
    end
    start = 1'b0;
    rst_n = 1'b1;
    check_eq("midrst_pulses", 32'(pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
